sample_history: RTL
===================

Name: sample_history

Overview:
- Gated sampled-value history recorder. It is the producer side of `$past`-style lookups.
- Each clock where the gating input is high, it captures one data sample into a ring buffer.
- A read port returns the sample captured N gated clocks ago, with a validity flag.
- Sits beside checker/assertion logic in regression designs. It provides `$past(expr, N, gate, @(posedge clk))` semantics in plain RTL, so expected values can be cross-checked.

Parameters:
- WIDTH, 8, sample data width in bits.
- DEPTH, 4, maximum supported lag (number of stored samples); must be >= 2; need not be a power of two.
- LAGW, $clog2(DEPTH+1), width of lag and fill-count fields (derived; not overridden).

Ports:
- clk  input  1  sampling clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- gate_i  input  1  sampling enable (expr2); a sample is captured only when high.
- clear_i  input  1  synchronous history flush.
- data_i  input  WIDTH  value to sample.
- lag_i  input  LAGW  requested lag N; 0 = current data_i.
- past_o  output  WIDTH  sample captured N gated clocks ago.
- past_valid_o  output  1  high when lag_i refers to a recorded sample.
- fill_o  output  LAGW  number of valid stored samples, 0..DEPTH.

Behaviour:
- State: storage[DEPTH] of WIDTH bits; write pointer wp in 0..DEPTH-1; count in 0..DEPTH.

Reset (rst=1 at posedge):
- wp=0, count=0.
- Storage contents are don't-care.
- Outputs after reset: fill_o=0, past_valid_o=0 for any lag_i>0, past_o=0 for lag_i>0.

Write side (posedge, rst=0):
- clear_i=1: wp=0, count=0. Clear wins over gate_i, so the concurrent sample is discarded.
- Otherwise, if gate_i=1:
  - storage[wp] <= data_i.
  - wp <= (wp==DEPTH-1) ? 0 : wp+1 (wrap-around).
  - count <= min(count+1, DEPTH) (saturating; oldest sample is overwritten when full).
- gate_i=0: no state change. Ungated clocks do not advance history; lag counts gated edges only.

Read side (combinational from current state; zero latency):
- lag_i=0: past_o=data_i, past_valid_o=1.
- 1 <= lag_i <= count: past_o = storage[(wp - lag_i) mod DEPTH], past_valid_o=1.
- lag_i > count, or lag_i > DEPTH: past_o=0 (initial value), past_valid_o=0.
- Index arithmetic is modulo DEPTH and done in LAGW+1 bits, so there is no underflow.
- A sample written at edge k is visible at lag 1 immediately after edge k. This matches `$past` under NBA: after edge k, lag 1 equals the data_i present at edge k.

Other rules:
- fill_o = count.
- Reset mid-operation: history is lost and count returns to 0 on that edge; gate_i is ignored during rst.

Optional Feature:
- Macro: SAMPLE_HISTORY_REG_OUT_EN.
- Defined:
  - past_o and past_valid_o are registered on posedge from the combinational read result.
  - This adds exactly 1 cycle of latency.
  - Both reset to 0 on rst; clear_i forces past_valid_o=0 next cycle.
  - fill_o remains combinational.
- Undefined: outputs are combinational as described above.

Test Plan:
1. Reset, then gate_i=1 continuously with data_i = 0,1,2,3,4,… per cycle; lag_i=1 → after the edge sampling value v, past_o=v and past_valid_o=1; lag_i=2 gives v-1 once fill_o>=2.
2. After reset, lag_i=3 with only 2 gated samples → past_valid_o=0, past_o=0; after the 3rd gated sample → past_valid_o=1.
3. DEPTH=4: gate 6 samples 10..15 → fill_o=4; lag_i=4 → 12; lag_i=1 → 15; lag_i=5 → invalid (wrap-around and saturation).
4. Samples 1,2,3 gated, then 3 cycles with gate_i=0 and data_i=99 → lag_i=1 stays 3 and fill_o stays 3 (ungated edges ignored).
5. clear_i=1 and gate_i=1 on the same edge with data_i=7 → fill_o=0 and lag_i=1 invalid; the next gated sample 8 → lag_i=1 returns 8.
6. Mid-stream rst with fill_o=4 → fill_o=0 next cycle and all lags >0 invalid. With SAMPLE_HISTORY_REG_OUT_EN defined, rerun scenario 1 and check past_o trails by one extra cycle.

Source files
------------

// File: rtl/sample_history.sv
// Gated sample history ring buffer providing $past(expr, N, gate) style lookups.
// Define SAMPLE_HISTORY_REG_OUT_EN to register past_o/past_valid_o (one extra cycle of latency).
module sample_history #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAGW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LAGW-1:0]  lag_i,
  output logic [WIDTH-1:0] past_o,
  output logic             past_valid_o,
  output logic [LAGW-1:0]  fill_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = LAGW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [LAGW-1:0]  count_q, count_d;
  logic             wr_en;

  logic [SW-1:0]    rd_sum, rd_mod;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_past;
  logic             rd_valid;

  assign wr_en = gate_i & ~clear_i & ~rst;

  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    if (clear_i) begin
      wp_d    = '0;
      count_d = '0;
    end else if (gate_i) begin
      wp_d    = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + AW'(1);
      count_d = (count_q == LAGW'(DEPTH)) ? count_q : count_q + LAGW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wp_q] <= data_i;
    end
  end

  // wp + DEPTH - lag stays non-negative and below 2*DEPTH whenever lag <= count.
  always_comb begin
    rd_sum = SW'(wp_q) + SW'(DEPTH) - SW'(lag_i);
    rd_mod = (rd_sum >= SW'(DEPTH)) ? rd_sum - SW'(DEPTH) : rd_sum;
    rd_idx = AW'(rd_mod);
  end

  always_comb begin
    rd_past  = '0;
    rd_valid = 1'b0;
    if (lag_i == '0) begin
      rd_past  = data_i;
      rd_valid = 1'b1;
    end else if (lag_i <= count_q) begin
      rd_past  = mem_q[rd_idx];
      rd_valid = 1'b1;
    end
  end

  assign fill_o = count_q;

`ifdef SAMPLE_HISTORY_REG_OUT_EN
  logic [WIDTH-1:0] past_q;
  logic             past_valid_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      past_q       <= '0;
      past_valid_q <= 1'b0;
    end else begin
      past_q       <= rd_past;
      past_valid_q <= rd_valid;
    end
  end

  assign past_o       = past_q;
  assign past_valid_o = past_valid_q;
`else
  assign past_o       = rd_past;
  assign past_valid_o = rd_valid;
`endif

endmodule
